clear_seq_phase_gen: RTL

CLEAR_SEQ_PHASE_GEN -- requirements
Module: clear_seq_phase_gen

---
 rtl/clear_seq_phase_gen.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/clear_seq_phase_gen.sv
// Clear-sequence phase generator: sends ISOLATE, CLEAR, POST_CLEAR and IDLE tokens
// downstream, waits for the far-side ack of each, and drives the local isolate/clear.
module clear_seq_phase_gen #(
   parameter int unsigned ClearCycles = 4,
   parameter int unsigned AckTimeout  = 1024
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clear_req_i,
   output logic [1:0] phase_o,
   output logic       phase_valid_o,
   input  logic       phase_ready_i,
   input  logic       phase_ack_i,
   output logic       isolate_o,
   output logic       clear_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       timeout_o
);

   localparam logic [1:0]  PH_IDLE      = 2'd0;
   localparam logic [1:0]  PH_ISOLATE   = 2'd1;
   localparam logic [1:0]  PH_CLEAR     = 2'd2;
   localparam logic [1:0]  PH_POST      = 2'd3;
   localparam logic [7:0]  HOLD_LOAD    = 8'(ClearCycles);
   localparam logic [15:0] TIMEOUT_LAST = 16'(AckTimeout - 1);
   localparam logic [15:0] WAIT_MAX     = 16'hFFFF;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SEND_ISO,
      S_WAIT_ISO,
      S_SEND_CLR,
      S_WAIT_CLR,
      S_HOLD,
      S_SEND_POST,
      S_WAIT_POST,
      S_SEND_IDLE,
      S_WAIT_IDLE
   } state_t;

   state_t      state_q;
   logic        pending_q;
   logic [7:0]  hold_cnt_q;
   logic [15:0] wait_cnt_q;
   logic        in_wait;

   function automatic state_t wait_of(input state_t s);
      case (s)
         S_SEND_ISO:  return S_WAIT_ISO;
         S_SEND_CLR:  return S_WAIT_CLR;
         S_SEND_POST: return S_WAIT_POST;
         S_SEND_IDLE: return S_WAIT_IDLE;
         default:     return S_IDLE;
      endcase
   endfunction

   assign in_wait = (state_q == S_WAIT_ISO)  || (state_q == S_WAIT_CLR) ||
                    (state_q == S_WAIT_POST) || (state_q == S_WAIT_IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         phase_o       <= PH_IDLE;
         phase_valid_o <= 1'b0;
         isolate_o     <= 1'b0;
         clear_o       <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         timeout_o     <= 1'b0;
         pending_q     <= 1'b0;
         hold_cnt_q    <= 8'd0;
         wait_cnt_q    <= 16'd0;
      end else begin
         done_o <= 1'b0;

         // Requests seen mid-sequence collapse into one follow-up sequence.
         if (state_q != S_IDLE && clear_req_i) begin
            pending_q <= 1'b1;
         end

         // The FSM keeps waiting after a timeout; the flag is only a sticky report.
         if (in_wait && !phase_ack_i) begin
            if (wait_cnt_q != WAIT_MAX) begin
               wait_cnt_q <= wait_cnt_q + 16'd1;
            end
            if (wait_cnt_q == TIMEOUT_LAST) begin
               timeout_o <= 1'b1;
            end
         end

         case (state_q)
            S_IDLE: begin
               if (clear_req_i || pending_q) begin
                  state_q       <= S_SEND_ISO;
                  pending_q     <= 1'b0;
                  busy_o        <= 1'b1;
                  phase_o       <= PH_ISOLATE;
                  phase_valid_o <= 1'b1;
               end
            end
            S_SEND_ISO, S_SEND_CLR, S_SEND_POST, S_SEND_IDLE: begin
               if (phase_valid_o && phase_ready_i) begin
                  phase_valid_o <= 1'b0;
                  wait_cnt_q    <= 16'd0;
                  state_q       <= wait_of(state_q);
               end
            end
            S_WAIT_ISO: begin
               if (phase_ack_i) begin
                  isolate_o     <= 1'b1;
                  state_q       <= S_SEND_CLR;
                  phase_o       <= PH_CLEAR;
                  phase_valid_o <= 1'b1;
               end
            end
            S_WAIT_CLR: begin
               if (phase_ack_i) begin
                  clear_o    <= 1'b1;
                  hold_cnt_q <= HOLD_LOAD;
                  state_q    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (hold_cnt_q <= 8'd1) begin
                  clear_o       <= 1'b0;
                  hold_cnt_q    <= 8'd0;
                  state_q       <= S_SEND_POST;
                  phase_o       <= PH_POST;
                  phase_valid_o <= 1'b1;
               end else begin
                  hold_cnt_q <= hold_cnt_q - 8'd1;
               end
            end
            S_WAIT_POST: begin
               if (phase_ack_i) begin
                  isolate_o     <= 1'b0;
                  state_q       <= S_SEND_IDLE;
                  phase_o       <= PH_IDLE;
                  phase_valid_o <= 1'b1;
               end
            end
            S_WAIT_IDLE: begin
               if (phase_ack_i) begin
                  state_q <= S_IDLE;
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
               end
            end
            default: begin
               state_q       <= S_IDLE;
               phase_valid_o <= 1'b0;
               busy_o        <= 1'b0;
            end
         endcase
      end
   end

endmodule
